// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time constants for the iterative CORDIC engine.
package cordic_pkg;

   typedef enum logic {
      MODE_ROT = 1'b0,   // rotation: sine and cosine of an angle
      MODE_VEC = 1'b1    // vectoring: magnitude and atan2 of a vector
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREP,
      ST_ITER,
      ST_FIN
   } state_e;

   localparam int  MAX_ITER = 32;
   localparam int  MAX_W    = 64;
   localparam real PI       = 3.14159265358979323846;

   typedef logic [MAX_ITER-1:0][MAX_W-1:0] atan_tab_t;

   // atan(2^-i) scaled so that 2^(width-1) represents pi; unused entries stay 0.
   function automatic atan_tab_t atan_table(input int width, input int iterations);
      atan_tab_t tab;
      real       scale;
      real       step;
      tab   = '0;
      scale = 1.0;
      for (int k = 0; k < width - 1; k++) scale = scale * 2.0;
      scale = scale / PI;
      step  = 1.0;
      for (int i = 0; i < MAX_ITER; i++) begin
         if (i < iterations) tab[i] = longint'($atan(step) * scale);
         step = step / 2.0;
      end
      return tab;
   endfunction

   // Reciprocal of the CORDIC gain in Q2.(width-2), rounded to nearest.
   function automatic longint inv_k(input int width, input int iterations);
      real k;
      real p;
      k = 1.0;
      p = 1.0;
      for (int i = 0; i < iterations; i++) begin
         k = k / $sqrt(1.0 + p);
         p = p / 4.0;
      end
      for (int j = 0; j < width - 2; j++) k = k * 2.0;
      return longint'(k);
   endfunction

endpackage

// File: rtl/cordic_iter.sv
// One CORDIC micro-rotation, purely combinational; the top time-shares it.
module cordic_iter
   import cordic_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int XW    = WIDTH + 2
) (
   input  logic signed [XW-1:0]    x_in,
   input  logic signed [XW-1:0]    y_in,
   input  logic signed [WIDTH-1:0] z_in,
   input  logic [4:0]              shift,
   input  mode_e                   mode,
   input  logic signed [WIDTH-1:0] atan_i,
   output logic signed [XW-1:0]    x_out,
   output logic signed [XW-1:0]    y_out,
   output logic signed [WIDTH-1:0] z_out
);

   logic signed [XW-1:0] x_sh;
   logic signed [XW-1:0] y_sh;
   logic                 d_pos;

   // Pick the rotation direction and apply the shift-and-add update.
   always_comb begin
      // NOTE: every combinational output is assigned on every path (defaults
      // first where branches differ) so synthesis never infers a latch.
      x_sh  = x_in >>> shift;
      y_sh  = y_in >>> shift;
      // d = +1 when z >= 0 (rotation) or when y < 0 (vectoring)
      d_pos = (mode == MODE_ROT) ? ~z_in[WIDTH-1] : y_in[XW-1];
      if (d_pos) begin
         x_out = x_in - y_sh;
         y_out = y_in + x_sh;
         z_out = z_in - atan_i;
      end else begin
         x_out = x_in + y_sh;
         y_out = y_in - x_sh;
         z_out = z_in + atan_i;
      end
   end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC: sin/cos in rotation mode, magnitude/atan2 in vectoring
// mode, one micro-rotation per clock behind a start/ready/done handshake.
module cordic_sincos
   import cordic_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ITERATIONS = 28
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    mode,
   input  logic signed [WIDTH-1:0] in_x,
   input  logic signed [WIDTH-1:0] in_y,
   input  logic signed [WIDTH-1:0] in_z,
   output logic                    ready,
   output logic                    done,
   output logic signed [WIDTH-1:0] out_x,
   output logic signed [WIDTH-1:0] out_y,
   output logic signed [WIDTH-1:0] out_z
);

   // x/y carry two extra integer bits so vectoring gain growth cannot overflow.
   localparam int XW = WIDTH + 2;
   localparam int PW = 2 * XW;

   localparam atan_tab_t               ATAN    = atan_table(WIDTH, ITERATIONS);
   localparam logic signed [XW-1:0]    INV_K   = XW'(inv_k(WIDTH, ITERATIONS));
   localparam logic signed [PW-1:0]    RND     = PW'(1) << (WIDTH - 3);
   localparam logic signed [PW-1:0]    MAG_MAX = (PW'(1) << (WIDTH - 1)) - PW'(1);

   state_e                  state_q, state_d;
   mode_e                   mode_q, mode_d;
   logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
   logic signed [WIDTH-1:0] z_q, z_d;
   logic [4:0]              iter_q, iter_d;
   logic                    fold_q, fold_d;   // neg (rotation) or addpi (vectoring)
   logic                    done_q, done_d;
   logic signed [WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;

   logic signed [XW-1:0]    it_x, it_y;
   logic signed [WIDTH-1:0] it_z;
   logic signed [WIDTH-1:0] atan_cur;
   logic signed [PW-1:0]    prod, mag;
   logic signed [WIDTH-1:0] fin_x, fin_y, fin_z;

   assign atan_cur = ATAN[iter_q][WIDTH-1:0];

   cordic_iter #(
      .WIDTH (WIDTH),
      .XW    (XW)
   ) u_iter (
      .x_in   (x_q),
      .y_in   (y_q),
      .z_in   (z_q),
      .shift  (iter_q),
      .mode   (mode_q),
      .atan_i (atan_cur),
      .x_out  (it_x),
      .y_out  (it_y),
      .z_out  (it_z)
   );

   // Undo the quadrant fold and gain-compensate the magnitude of the final step.
   always_comb begin
      prod = PW'(it_x) * PW'(INV_K);
      mag  = (prod + RND) >>> (WIDTH - 2);
      if (mode_q == MODE_ROT) begin
         fin_x = fold_q ? -it_x[WIDTH-1:0] : it_x[WIDTH-1:0];
         fin_y = fold_q ? -it_y[WIDTH-1:0] : it_y[WIDTH-1:0];
         fin_z = it_z;
      end else begin
         fin_x = (mag > MAG_MAX) ? MAG_MAX[WIDTH-1:0] : mag[WIDTH-1:0];
         fin_y = it_y[WIDTH-1:0];
         // adding pi modulo 2^WIDTH is just an MSB flip
         fin_z = fold_q ? {~it_z[WIDTH-1], it_z[WIDTH-2:0]} : it_z;
      end
   end

   // Next-state logic for the IDLE -> PREP -> ITER -> FIN sequence.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      iter_d  = iter_q;
      fold_d  = fold_q;
      done_d  = 1'b0;
      out_x_d = out_x_q;
      out_y_d = out_y_q;
      out_z_d = out_z_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d = mode_e'(mode);
               fold_d = 1'b0;
               iter_d = '0;
               if (mode) begin
                  x_d = XW'(in_x);
                  y_d = XW'(in_y);
                  z_d = '0;
               end else begin
                  x_d = INV_K;
                  y_d = '0;
                  z_d = in_z;
               end
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            // Fold into the right half-plane where CORDIC converges.
            if (mode_q == MODE_ROT) begin
               if (z_q[WIDTH-1] != z_q[WIDTH-2]) begin
                  z_d    = {~z_q[WIDTH-1], z_q[WIDTH-2:0]};
                  fold_d = 1'b1;
               end
            end else if (x_q[XW-1]) begin
               x_d    = -x_q;
               y_d    = -y_q;
               fold_d = 1'b1;
            end
            iter_d  = '0;
            state_d = ST_ITER;
         end
         ST_ITER: begin
            x_d    = it_x;
            y_d    = it_y;
            z_d    = it_z;
            iter_d = iter_q + 5'd1;
            if (iter_q == 5'(ITERATIONS - 1)) begin
               out_x_d = fin_x;
               out_y_d = fin_y;
               out_z_d = fin_z;
               done_d  = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      // NOTE: flops take non-blocking assignments so every register samples
      // its pre-edge inputs regardless of statement order.
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_ROT;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         iter_q  <= '0;
         fold_q  <= 1'b0;
         done_q  <= 1'b0;
         out_x_q <= '0;
         out_y_q <= '0;
         out_z_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         iter_q  <= iter_d;
         fold_q  <= fold_d;
         done_q  <= done_d;
         out_x_q <= out_x_d;
         out_y_q <= out_y_d;
         out_z_q <= out_z_d;
      end
   end

   assign ready = (state_q == ST_IDLE);
   assign done  = done_q;
   assign out_x = out_x_q;
   assign out_y = out_y_q;
   assign out_z = out_z_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Scoreboard bench for cordic_sincos at WIDTH=32, ITERATIONS=28.
module tb_cordic_sincos;

   localparam int  WIDTH      = 32;
   localparam int  ITERATIONS = 28;
   localparam int  LAT        = ITERATIONS + 2;
   localparam int  TOL        = 64;
   localparam real PI_R       = 3.14159265358979323846;
   localparam real TWO30      = 1073741824.0;
   localparam real TWO31      = 2147483648.0;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic                    mode;
   logic signed [WIDTH-1:0] in_x, in_y, in_z;
   logic                    ready;
   logic                    done;
   logic signed [WIDTH-1:0] out_x, out_y, out_z;

   typedef struct {
      string       tag;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   cordic_sincos #(
      .WIDTH      (WIDTH),
      .ITERATIONS (ITERATIONS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mode  (mode),
      .in_x  (in_x),
      .in_y  (in_y),
      .in_z  (in_z),
      .ready (ready),
      .done  (done),
      .out_x (out_x),
      .out_y (out_y),
      .out_z (out_z)
   );

   // Compare modulo 2^32 so angles near +/-pi are judged by their wrapped distance.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                        input int tol = 0);
      longint diff;
      diff = longint'($signed(got - exp));
      if (diff < 0) diff = -diff;
      n_checks++;
      if (diff > longint'(tol)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, $signed(got), $signed(exp), tol);
      end
   endtask

   function automatic exp_t mk(input string tag, input logic [31:0] x, y, z);
      exp_t e;
      e.tag = tag;
      e.x   = x;
      e.y   = y;
      e.z   = z;
      return e;
   endfunction

   // Real-arithmetic reference: ideal sin/cos or magnitude/atan2.
   function automatic exp_t model(input string tag, input logic m,
                                  input logic signed [31:0] x, y, z);
      exp_t e;
      real  a;
      e.tag = tag;
      if (!m) begin
         a   = $itor(z) * PI_R / TWO31;
         e.x = 32'(longint'($cos(a) * TWO30));
         e.y = 32'(longint'($sin(a) * TWO30));
         e.z = '0;
      end else begin
         e.x = 32'(longint'($sqrt($itor(x) * $itor(x) + $itor(y) * $itor(y))));
         e.y = '0;
         e.z = 32'(longint'($atan2($itor(y), $itor(x)) * TWO31 / PI_R));
      end
      return e;
   endfunction

   // Every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", done, 1'b0);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, "_x"}, out_x, mon_e.x, TOL);
            check({mon_e.tag, "_y"}, out_y, mon_e.y, TOL);
            check({mon_e.tag, "_z"}, out_z, mon_e.z, TOL);
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check("ready_timeout", ready, 1'b1);
   endtask

   // Issue one operation; optionally pulse start with other inputs mid-flight.
   task automatic run_op(input exp_t e, input logic m, input logic signed [31:0] x, y, z,
                         input int pulse_at = 0);
      int lat;
      int ready_hi;
      wait_ready();
      mode  = m;
      in_x  = x;
      in_y  = y;
      in_z  = z;
      start = 1'b1;
      @(posedge clk);
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      mode  = ~m;
      in_x  = ~x;
      in_y  = ~y;
      in_z  = ~z;
      lat      = 1;
      ready_hi = 0;
      while (!done && lat < LAT + 20) begin
         if (ready) ready_hi++;
         start = (lat == pulse_at);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({e.tag, "_latency"}, lat, LAT);
      check({e.tag, "_ready_low"}, ready_hi, 0);
      check({e.tag, "_ready_at_done"}, ready, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t                e;
      int                  lat;
      int                  saw;
      logic signed [31:0]  rx, ry, rz;

      reset = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      in_x  = '0;
      in_y  = '0;
      in_z  = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", ready, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_out_x", out_x, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_z", out_z, 0);

      // reset and start together: reset must win and leave the engine idle
      start = 1'b1;
      in_z  = 32'sh2000_0000;
      @(negedge clk);
      check("rst_beats_start", ready, 1'b1);
      reset = 1'b0;
      start = 1'b0;

      // directed cases with hand-derived expectations
      run_op(mk("rot_0", 32'sd1073741824, 32'sd0, 32'sd0), 1'b0, 0, 0, 32'sd0);
      run_op(mk("rot_pi2_pulse", 32'sd0, 32'sd1073741824, 32'sd0), 1'b0, 0, 0,
             32'sd1073741824, 10);
      run_op(mk("rot_m3pi4", -32'sd759250125, -32'sd759250125, 32'sd0), 1'b0, 0, 0,
             -32'sd1610612736);
      run_op(mk("rot_mpi", -32'sd1073741824, 32'sd0, 32'sd0), 1'b0, 0, 0,
             32'h8000_0000);
      run_op(mk("vec_y", 32'sd536870912, 32'sd0, 32'sd1073741824), 1'b1,
             32'sd0, 32'sd536870912, 0);
      run_op(mk("vec_q3", 32'sd759250125, 32'sd0, -32'sd1610612736), 1'b1,
             -32'sd536870912, -32'sd536870912, 0);

      // random angles and vectors against the real-math reference
      for (int i = 0; i < 4; i++) begin
         rz = $urandom;
         run_op(model($sformatf("rot_rnd%0d", i), 1'b0, 0, 0, rz), 1'b0, 0, 0, rz);
      end
      for (int i = 0; i < 4; i++) begin
         rx = int'($urandom_range(2147483646, 0)) - 1073741823;
         ry = int'($urandom_range(2147483646, 0)) - 1073741823;
         run_op(model($sformatf("vec_rnd%0d", i), 1'b1, rx, ry, 0), 1'b1, rx, ry, 0);
      end

      // start held high: second accept lands one cycle after done
      e = model("held", 1'b0, 0, 0, 32'sh2000_0000);
      wait_ready();
      mode  = 1'b0;
      in_z  = 32'sh2000_0000;
      start = 1'b1;
      @(posedge clk);
      sb_q.push_back(e);
      sb_q.push_back(e);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < LAT + 20);
      check("held_latency", lat, LAT);
      @(negedge clk);
      check("held_ready_after_done", ready, 1'b1);
      @(negedge clk);
      check("held_second_accept", ready, 1'b0);
      start = 1'b0;
      lat   = 1;
      while (!done && lat < LAT + 20) begin
         @(negedge clk);
         lat++;
      end
      check("held_second_latency", lat, LAT);

      // reset during ITER aborts the operation and clears the outputs
      wait_ready();
      mode  = 1'b0;
      in_z  = 32'sh1000_0000;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ready", ready, 1'b1);
      check("abort_done", done, 1'b0);
      check("abort_out_x", out_x, 0);
      check("abort_out_y", out_y, 0);
      check("abort_out_z", out_z, 0);
      saw = 0;
      repeat (LAT + 10) begin
         @(negedge clk);
         if (done) saw++;
      end
      check("abort_no_done", saw, 0);

      // a fresh operation after the abort completes normally
      rx = -32'sd300000000;
      ry = 32'sd700000000;
      run_op(model("post_abort", 1'b1, rx, ry, 0), 1'b1, rx, ry, 0);

      repeat (5) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
